// File: rtl/juego_pkg.sv
// Shared types and defaults for the column-drop game: FSM states,
// end-of-game codes and board geometry.
package juego_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ESPERA    = 3'd1,
    AUTO      = 3'd2,
    ESCRIBIR  = 3'd3,
    VERIFICAR = 3'd4,
    FIN       = 3'd5
  } estado_t;

  localparam logic [1:0] FIN_NINGUNO = 2'b00;
  localparam logic [1:0] FIN_P0      = 2'b01;
  localparam logic [1:0] FIN_P1      = 2'b10;
  localparam logic [1:0] FIN_EMPATE  = 2'b11;

  localparam int N_COLS_DEF    = 7;
  localparam int MAX_MOVES_DEF = 42;

endpackage

// File: rtl/controlador_turnos.sv
// Turn sequencer: arbitrates player request vs. timeout auto-move, searches for a
// free column on timeout, writes the board and waits for the win-check verdict.
module controlador_turnos
  import juego_pkg::*;
#(
  parameter int N_COLS    = N_COLS_DEF,
  parameter int COL_W     = 3,
  parameter int MAX_MOVES = MAX_MOVES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inicio,
  input  logic              jugada_req,
  input  logic [COL_W-1:0]  jugada_col,
  output logic              jugada_ack,
  output logic              jugada_rech,
  input  logic              tiempo,
  input  logic [7:0]        posicion_ra,
  output logic              guardado,
  input  logic [N_COLS-1:0] col_llena,
  output logic              tablero_we,
  output logic [COL_W-1:0]  tablero_col,
  output logic              tablero_jugador,
  input  logic              chk_valid,
  input  logic              gano,
  output logic              jugador,
  output logic [1:0]        estado_fin,
  output logic [5:0]        contador_jugadas
);

  localparam logic [7:0]       N_COLS_8  = 8'(N_COLS);
  localparam logic [COL_W-1:0] ULT_COL   = COL_W'(N_COLS - 1);
  localparam logic [5:0]       MAX_MOV_6 = 6'(MAX_MOVES);

  estado_t          r_state, w_state_next;
  logic [COL_W-1:0] r_cand, w_cand_next;
  logic [COL_W-1:0] r_intentos, w_intentos_next;
  logic             r_jugada_ack, w_jugada_ack_next;
  logic             r_jugada_rech, w_jugada_rech_next;
  logic             r_guardado, w_guardado_next;
  logic             r_tablero_we, w_tablero_we_next;
  logic [COL_W-1:0] r_tablero_col, w_tablero_col_next;
  logic             r_tablero_jugador, w_tablero_jugador_next;
  logic             r_jugador, w_jugador_next;
  logic [1:0]       r_estado_fin, w_estado_fin_next;
  logic [5:0]       r_contador, w_contador_next;

  // Column indices past N_COLS read as full, so range and fullness share one test
  logic [(2**COL_W)-1:0] w_llena_ext;
  genvar gi;
  generate
    for (gi = 0; gi < 2**COL_W; gi++) begin : g_llena
      if (gi < N_COLS) begin : g_real
        assign w_llena_ext[gi] = col_llena[gi];
      end else begin : g_fuera
        assign w_llena_ext[gi] = 1'b1;
      end
    end
  endgenerate

  // A request still held during its reject pulse is not re-judged
  logic             w_req_vista, w_req_ok, w_req_mal, w_cand_libre;
  logic [COL_W-1:0] w_ra_cand, w_cand_sig;
  assign w_req_vista  = jugada_req && !r_jugada_rech;
  assign w_req_ok     = w_req_vista && !w_llena_ext[jugada_col];
  assign w_req_mal    = w_req_vista && w_llena_ext[jugada_col];
  assign w_cand_libre = !w_llena_ext[r_cand];
  assign w_ra_cand    = COL_W'(posicion_ra % N_COLS_8);
  assign w_cand_sig   = (r_cand == ULT_COL) ? '0 : r_cand + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= IDLE;
      r_cand            <= '0;
      r_intentos        <= '0;
      r_jugada_ack      <= 1'b0;
      r_jugada_rech     <= 1'b0;
      r_guardado        <= 1'b1;
      r_tablero_we      <= 1'b0;
      r_tablero_col     <= '0;
      r_tablero_jugador <= 1'b0;
      r_jugador         <= 1'b0;
      r_estado_fin      <= FIN_NINGUNO;
      r_contador        <= '0;
    end else begin
      r_state           <= w_state_next;
      r_cand            <= w_cand_next;
      r_intentos        <= w_intentos_next;
      r_jugada_ack      <= w_jugada_ack_next;
      r_jugada_rech     <= w_jugada_rech_next;
      r_guardado        <= w_guardado_next;
      r_tablero_we      <= w_tablero_we_next;
      r_tablero_col     <= w_tablero_col_next;
      r_tablero_jugador <= w_tablero_jugador_next;
      r_jugador         <= w_jugador_next;
      r_estado_fin      <= w_estado_fin_next;
      r_contador        <= w_contador_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, FIN: if (inicio) w_state_next = ESPERA;
      ESPERA: begin
        if (w_req_ok)    w_state_next = ESCRIBIR;
        else if (tiempo) w_state_next = AUTO;
      end
      AUTO: begin
        if (w_cand_libre)                w_state_next = ESCRIBIR;
        else if (r_intentos == ULT_COL)  w_state_next = FIN;
      end
      ESCRIBIR: w_state_next = VERIFICAR;
      VERIFICAR: begin
        if (chk_valid) begin
          if (gano || r_contador == MAX_MOV_6) w_state_next = FIN;
          else                                 w_state_next = ESPERA;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_cand_next            = r_cand;
    w_intentos_next        = r_intentos;
    w_jugada_ack_next      = 1'b0;
    w_jugada_rech_next     = 1'b0;
    w_tablero_we_next      = 1'b0;
    w_tablero_col_next     = r_tablero_col;
    w_tablero_jugador_next = r_tablero_jugador;
    w_jugador_next         = r_jugador;
    w_estado_fin_next      = r_estado_fin;
    w_contador_next        = r_contador;
    w_guardado_next        = (w_state_next == IDLE) || (w_state_next == FIN);

    case (r_state)
      IDLE, FIN: begin
        if (inicio) begin
          w_jugador_next    = 1'b0;
          w_contador_next   = '0;
          w_estado_fin_next = FIN_NINGUNO;
        end
      end
      ESPERA: begin
        if (w_req_ok) begin
          w_jugada_ack_next  = 1'b1;
          w_tablero_col_next = jugada_col;
        end else begin
          w_jugada_rech_next = w_req_mal;
          if (tiempo) begin
            w_cand_next     = w_ra_cand;
            w_intentos_next = '0;
          end
        end
      end
      AUTO: begin
        if (w_cand_libre) begin
          w_tablero_col_next = r_cand;
        end else if (r_intentos == ULT_COL) begin
          w_estado_fin_next = FIN_EMPATE;
        end else begin
          w_cand_next     = w_cand_sig;
          w_intentos_next = r_intentos + 1'b1;
        end
      end
      VERIFICAR: begin
        if (chk_valid) begin
          if (gano) begin
            w_estado_fin_next = {r_jugador, ~r_jugador};
          end else if (r_contador == MAX_MOV_6) begin
            w_estado_fin_next = FIN_EMPATE;
          end else begin
            w_jugador_next  = ~r_jugador;
            w_guardado_next = 1'b1;
          end
        end
      end
      default: ;
    endcase

    // Every entry into ESCRIBIR commits the move for the current player
    if (w_state_next == ESCRIBIR) begin
      w_tablero_we_next      = 1'b1;
      w_tablero_jugador_next = r_jugador;
      w_contador_next        = r_contador + 1'b1;
    end
  end

  assign jugada_ack       = r_jugada_ack;
  assign jugada_rech      = r_jugada_rech;
  assign guardado         = r_guardado;
  assign tablero_we       = r_tablero_we;
  assign tablero_col      = r_tablero_col;
  assign tablero_jugador  = r_tablero_jugador;
  assign jugador          = r_jugador;
  assign estado_fin       = r_estado_fin;
  assign contador_jugadas = r_contador;

endmodule

// File: doc/controlador_turnos.md
# controlador_turnos

Turn sequencer for the two-player column-drop game. Alternates players, arbitrates each turn's move between the player's request and the timer's timeout auto-move, and searches for a non-full column when the random move lands on a full one. Issues the board write, waits for the win checker's verdict, then restarts the turn timer or ends the game. It sits between the input/debounce logic, `temporizador` (timer) and the board/win-check logic.

## Interface
- `N_COLS`, 7: number of board columns.
- `COL_W`, 3: column index width; must satisfy 2^COL_W ≥ N_COLS.
- `MAX_MOVES`, 42: move count that declares a draw.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `inicio` in 1: start/restart pulse.
- `jugada_req` in 1: player move request, held until `jugada_ack` or `jugada_rech`.
- `jugada_col` in COL_W: requested column.
- `jugada_ack` out 1: one-cycle accept pulse.
- `jugada_rech` out 1: one-cycle reject pulse.
- `tiempo` in 1: timeout pulse from the timer.
- `posicion_ra` in 8: random value from the timer; valid when `tiempo`=1.
- `guardado` out 1: timer clear (restart/freeze).
- `col_llena` in N_COLS: per-column full flags from the board.
- `tablero_we` out 1: one-cycle board write strobe.
- `tablero_col` out COL_W: column being written.
- `tablero_jugador` out 1: player being written.
- `chk_valid` in 1: win-check result valid.
- `gano` in 1: win flag, qualified by `chk_valid`.
- `jugador` out 1: current player.
- `estado_fin` out 2: 00 = none, 01 = P0 wins, 10 = P1 wins, 11 = draw.
- `contador_jugadas` out 6: moves placed.

## Operation
- FSM states: IDLE, ESPERA, AUTO, ESCRIBIR, VERIFICAR, FIN.
- IDLE: `guardado` is held at 1. On `inicio`, go to ESPERA with `jugador`=0, `contador_jugadas`=0, `estado_fin`=00.
- ESPERA: `guardado`=0.
  - Valid request: `jugada_req` with `jugada_col`<N_COLS and `!col_llena[jugada_col]`. Pulse `jugada_ack`, latch the column, go to ESCRIBIR.
  - Invalid request: pulse `jugada_rech` and stay in ESPERA, unless `tiempo` is also high.
  - `tiempo` with no valid request: candidate = `posicion_ra` mod N_COLS (unsigned, 8-bit), go to AUTO.
  - Simultaneous valid request and `tiempo`: the player wins and `tiempo` is dropped.
- AUTO: checks one candidate per cycle.
  - If `!col_llena[cand]`: latch it and go to ESCRIBIR.
  - Otherwise: cand = (cand = N_COLS-1) ? 0 : cand+1.
  - After N_COLS failed checks: go to FIN with `estado_fin`=11.
- ESCRIBIR: `tablero_we`=1 for one cycle with the latched column and `jugador`. Increment `contador_jugadas`. Go to VERIFICAR.
- VERIFICAR: wait for `chk_valid`; `jugada_req` and `tiempo` are ignored.
  - `gano`=1: `estado_fin` = {`jugador`, !`jugador`}, go to FIN.
  - Else if `contador_jugadas`=MAX_MOVES: `estado_fin`=11, go to FIN.
  - Else: toggle `jugador`, pulse `guardado` one cycle, return to ESPERA.
- FIN: `guardado` is held at 1; all requests are ignored. `inicio` behaves as in IDLE.
- `inicio` outside IDLE/FIN is ignored.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE, `guardado`=1.
  - `jugada_ack`, `jugada_rech`, `tablero_we` = 0.
  - `tablero_col`, `tablero_jugador` = 0.
  - `jugador`=0, `estado_fin`=00, `contador_jugadas`=0.
- Valid request sampled at edge t: `jugada_ack`=1 and `tablero_we`=1 together in cycle t+1; VERIFICAR from t+2.
- Requester must drop `jugada_req` in the cycle after `jugada_ack` or `jugada_rech`. ESPERA is re-entered no earlier than t+3.
- Timeout auto-move: `tablero_we` asserts k+2 cycles after `tiempo`, where k = number of full columns skipped (0…N_COLS-1).
- `guardado` pulse on turn change: coincides with the first ESPERA cycle.
- `rst` in any state, including mid-AUTO or mid-VERIFICAR, returns to the reset values on the next edge. No write strobe follows a reset.

## Structure
- Package `juego_pkg`:
  - `estado_t` enum for the FSM states.
  - `estado_fin` codes: `FIN_NINGUNO`, `FIN_P0`, `FIN_P1`, `FIN_EMPATE`.
  - Defaults `N_COLS_DEF`=7, `MAX_MOVES_DEF`=42.
- Single module, no sub-module. The wrap-around search is a registered candidate counter inside AUTO.

## Test plan
- Reset → `inicio` → `jugada_col`=3, all columns free: `jugada_ack` and `tablero_we`(col 3, P0) at +1. `chk_valid`, `gano`=0 → `jugador`=1, one-cycle `guardado`, `contador_jugadas`=1.
- Invalid requests: `jugada_col`=7 → `jugada_rech`, no `tablero_we`. `jugada_col`=2 with `col_llena`[2]=1 → `jugada_rech`, no `tablero_we`. State stays ESPERA in both cases.
- `tiempo` with `posicion_ra`=200 (mod 7 = 4) and columns 4 and 5 full → `tablero_we` on column 6, 4 cycles after `tiempo`.
- Wrap-around: `posicion_ra`=6 with columns 6 and 0 full → writes column 1. Also: `tiempo` in the same cycle as a valid request for column 2 → column 2 written and `jugada_ack` asserted.
- `gano`=1 on P1's move → `estado_fin`=10, `guardado` held at 1, later `jugada_req`/`tiempo` produce no write. `inicio` → ESPERA, `jugador`=0, `contador_jugadas`=0.
- 42 moves with no win → `estado_fin`=11. Separately, `rst` asserted in the second AUTO cycle → all reset values, no `tablero_we`.
